updown_counter: RTL and testbench

Parametrised up/down counter that succeeds the basic 8-bit incrementer used in the datapath control blocks. It adds a run-time programmable terminal value, count direction, three overflow modes (wrap, saturate, one-shot), separate carry/borrow pulses and a combinational terminal-count output for cascading counters into wider or multi-stage timers. It sits next to the timer and sequencer logic as the common counting primitive.

---
 rtl/counter_pkg.sv | 15 +
 rtl/updown_counter.sv | 100 ++++++++++
 tb/tb_updown_counter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counting primitive.
package counter_pkg;

    // Overflow behaviour selected by the mode input; 2'd3 behaves as wrap.
    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    // RUN counts normally; DONE is the parked state after a one-shot finishes.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/updown_counter.sv
// Parametrised up/down counter with programmable terminal value, wrap /
// saturate / one-shot overflow handling, carry/borrow pulses and a
// combinational terminal-count output for cascading stages.
module updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             done,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    state_t           state_q, state_d;
    logic             at_term;

    // Terminal detection: up uses >= so a max_val lowered below the count
    // still triggers terminal handling on the next step.
    always_comb begin
        at_term = dir ? (count_q >= max_val) : (count_q == '0);
    end

    // Next-state selection: clr > load > enabled step > hold.
    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (clr) begin
            count_d = RESET_VAL;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = (data_in > max_val) ? max_val : data_in;
            state_d = ST_RUN;
        end else if (en && state_q == ST_RUN) begin
            if (!at_term) begin
                count_d = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else begin
                case (mode)
                    MODE_SAT: begin
                        if (dir) count_d = max_val;
                    end
                    MODE_ONESHOT: begin
                        if (dir) count_d = max_val;
                        state_d = ST_DONE;
                    end
                    default: begin
                        if (dir) begin
                            count_d = '0;
                            carry_d = 1'b1;
                        end else begin
                            count_d  = max_val;
                            borrow_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State, count and pulse registers; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= RESET_VAL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            state_q  <= ST_RUN;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            state_q  <= state_d;
        end
    end

    // Outputs; tc is zero-latency so a following stage can use it as en.
    always_comb begin
        count      = count_q;
        carry_out  = carry_q;
        borrow_out = borrow_q;
        done       = (state_q == ST_DONE);
        tc         = en & ~done & at_term;
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (WIDTH=8, RESET_VAL=0).
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n, clr, load, en, dir;
    logic [7:0] data_in, max_val, count;
    logic [1:0] mode;
    logic       carry_out, borrow_out, done, tc;

    int n_chk  = 0;
    int n_fail = 0;

    updown_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .data_in(data_in),
        .en(en), .dir(dir), .mode(mode), .max_val(max_val), .count(count),
        .carry_out(carry_out), .borrow_out(borrow_out), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; load = 0; en = 0; dir = 1; mode = 2'd0;
        data_in = 0; max_val = 8'd9;
        #2;
        n_chk++;
        if ({count, carry_out, borrow_out, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: count=%0d c=%b b=%b d=%b expected 0 0 0 0", count, carry_out, borrow_out, done);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        logic [7:0] e;
        max_val = 8'd9; dir = 1; mode = 2'd0; en = 1;
        for (int k = 0; k < 12; k++) begin
            n_chk++;
            if (tc !== (k % 10 == 9)) begin
                n_fail++;
                $display("FAIL wrap_up_tc k=%0d: tc=%b expected %b", k, tc, (k % 10 == 9));
            end
            step();
            e = 8'((k + 1) % 10);
            n_chk++;
            if (count !== e || carry_out !== (e == 0) || borrow_out !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_up k=%0d: count=%0d carry=%b expected %0d %b", k, count, carry_out, e, (e == 0));
            end
        end
        en = 0;
        step();
        n_chk++;
        if (count !== 8'd2 || carry_out !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_up_hold: count=%0d carry=%b tc=%b expected 2 0 0", count, carry_out, tc);
        end
    endtask

    task automatic test_wrap_down();
        logic [7:0] exp_c [5] = '{8'd2, 8'd1, 8'd0, 8'd5, 8'd4};
        // load and en together: load wins
        max_val = 8'd5; dir = 0; mode = 2'd0; data_in = 8'd3; load = 1; en = 1;
        step();
        load = 0;
        n_chk++;
        if (count !== 8'd3) begin
            n_fail++;
            $display("FAIL load_over_en: count=%0d expected 3", count);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++;
            if (count !== exp_c[k] || borrow_out !== (k == 3) || carry_out !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_down k=%0d: count=%0d borrow=%b expected %0d %b", k, count, borrow_out, exp_c[k], (k == 3));
            end
        end
        en = 0;
    endtask

    task automatic test_sat();
        logic [7:0] exp_c [5] = '{8'd199, 8'd200, 8'd200, 8'd200, 8'd200};
        mode = 2'd1; max_val = 8'd200; dir = 1; data_in = 8'd198; load = 1;
        step();
        load = 0; en = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++;
            if (count !== exp_c[k] || carry_out !== 1'b0 || tc !== (exp_c[k] == 8'd200)) begin
                n_fail++;
                $display("FAIL sat k=%0d: count=%0d carry=%b tc=%b expected %0d 0 %b", k, count, carry_out, tc, exp_c[k], (exp_c[k] == 8'd200));
            end
        end
        en = 0;
    endtask

    task automatic test_oneshot();
        mode = 2'd2; dir = 0; max_val = 8'd50; data_in = 8'd2; load = 1;
        step();
        load = 0; en = 1;
        step();
        n_chk++;
        if (count !== 8'd1 || done !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_1: count=%0d done=%b expected 1 0", count, done);
        end
        step();
        n_chk++;
        if (count !== 8'd0 || done !== 1'b0 || tc !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_0: count=%0d done=%b tc=%b expected 0 0 1", count, done, tc);
        end
        step();
        n_chk++;
        if (count !== 8'd0 || done !== 1'b1 || borrow_out !== 1'b0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_done: count=%0d done=%b borrow=%b tc=%b expected 0 1 0 0", count, done, borrow_out, tc);
        end
        mode = 2'd0; dir = 1;  // changing mode/dir must not leave DONE
        step(); step();
        n_chk++;
        if (count !== 8'd0 || done !== 1'b1 || carry_out !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_stay: count=%0d done=%b carry=%b expected 0 1 0", count, done, carry_out);
        end
        data_in = 8'd7; load = 1;
        step();
        load = 0;
        n_chk++;
        if (count !== 8'd7 || done !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_reload: count=%0d done=%b expected 7 0", count, done);
        end
        step();
        n_chk++;
        if (count !== 8'd8) begin
            n_fail++; $display("FAIL oneshot_resume: count=%0d expected 8", count);
        end
        en = 0;
    endtask

    task automatic test_load_clr();
        mode = 2'd0; dir = 1; max_val = 8'd100; data_in = 8'd250; load = 1;
        step();
        n_chk++;
        if (count !== 8'd100) begin
            n_fail++; $display("FAIL load_clamp: count=%0d expected 100", count);
        end
        clr = 1; data_in = 8'd33;
        step();
        clr = 0; load = 0;
        n_chk++;
        if (count !== 8'd0) begin
            n_fail++; $display("FAIL clr_over_load: count=%0d expected 0", count);
        end
        max_val = 8'd200; data_in = 8'd60; load = 1;
        step();
        load = 0; max_val = 8'd50; en = 1;
        step();
        en = 0;
        n_chk++;
        if (count !== 8'd0 || carry_out !== 1'b1) begin
            n_fail++; $display("FAIL max_lowered: count=%0d carry=%b expected 0 1", count, carry_out);
        end
        step();
        n_chk++;
        if (carry_out !== 1'b0) begin
            n_fail++; $display("FAIL carry_one_cycle: carry=%b expected 0", carry_out);
        end
        max_val = 8'd0; en = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (count !== 8'd0 || carry_out !== 1'b1) begin
                n_fail++; $display("FAIL max_zero k=%0d: count=%0d carry=%b expected 0 1", k, count, carry_out);
            end
        end
        en = 0;
    endtask

    task automatic test_async_reset();
        mode = 2'd2; dir = 1; max_val = 8'd42; data_in = 8'd41; load = 1;
        step();
        load = 0; en = 1;
        step(); step();
        n_chk++;
        if (count !== 8'd42 || done !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: count=%0d done=%b expected 42 1", count, done);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (count !== 8'd0 || done !== 1'b0 || carry_out !== 1'b0 || borrow_out !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: count=%0d done=%b c=%b b=%b expected 0 0 0 0", count, done, carry_out, borrow_out);
        end
        en = 0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat();
        test_oneshot();
        test_load_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
